// File: rtl/alarm_ring_ctrl_pkg.sv
// rtl/alarm_ring_ctrl_pkg.sv - shared state encoding, BCD limits and LED patterns for the alarm path
package alarm_ring_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } ctrl_state_e;

  localparam logic [3:0] DIGIT_MAX     = 4'd9;
  localparam logic [3:0] H_TEN_MAX     = 4'd2;
  localparam logic [3:0] H_ONE_MAX_20S = 4'd3;
  localparam logic [3:0] M_TEN_MAX     = 4'd5;

  localparam logic [7:0] LED_ON  = 8'hFF;
  localparam logic [7:0] LED_OFF = 8'h00;

  typedef struct packed {
    logic [3:0] h_ten;
    logic [3:0] h_one;
    logic [3:0] m_ten;
    logic [3:0] m_one;
  } bcd_time_t;

  // 00:00..23:59 with every digit a legal BCD digit
  function automatic logic bcd_time_valid(bcd_time_t t);
    return (t.h_ten <= H_TEN_MAX) && (t.h_one <= DIGIT_MAX) &&
           (t.m_ten <= M_TEN_MAX) && (t.m_one <= DIGIT_MAX) &&
           !((t.h_ten == H_TEN_MAX) && (t.h_one > H_ONE_MAX_20S));
  endfunction

endpackage

// File: rtl/alarm_ring_ctrl_bcd_time_add.sv
// rtl/alarm_ring_ctrl_bcd_time_add.sv - combinational HH:MM BCD plus a fixed minute count, 24 h wrap
module alarm_ring_ctrl_bcd_time_add
  import alarm_ring_ctrl_pkg::*;
#(
  parameter int ADD_MIN = 5
) (
  input  logic [15:0] time_i,
  output logic [15:0] time_o
);

  bcd_time_t  in_t;
  bcd_time_t  out_t;
  logic [6:0] min_bin;
  logic [6:0] min_sum;
  logic [6:0] min_wrap;
  logic [4:0] hr_bin;
  logic [4:0] hr_sum;
  logic [4:0] hr_wrap;
  logic       carry;

  // ADD_MIN is at most 59, so at most one hour of carry is possible
  always_comb begin
    in_t     = bcd_time_t'(time_i);
    min_bin  = 7'(in_t.m_ten) * 7'd10 + 7'(in_t.m_one);
    min_sum  = min_bin + 7'(ADD_MIN);
    carry    = (min_sum >= 7'd60);
    min_wrap = carry ? (min_sum - 7'd60) : min_sum;
    hr_bin   = 5'(in_t.h_ten) * 5'd10 + 5'(in_t.h_one);
    hr_sum   = hr_bin + 5'(carry);
    hr_wrap  = (hr_sum >= 5'd24) ? (hr_sum - 5'd24) : hr_sum;
    out_t.h_ten = 4'(hr_wrap / 5'd10);
    out_t.h_one = 4'(hr_wrap % 5'd10);
    out_t.m_ten = 4'(min_wrap / 7'd10);
    out_t.m_one = 4'(min_wrap % 7'd10);
  end

  assign time_o = out_t;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// rtl/alarm_ring_ctrl.sv - alarm arm/compare/ring FSM with snooze, dismiss and ring timeout
module alarm_ring_ctrl
  import alarm_ring_ctrl_pkg::*;
#(
  parameter int BLINK_HALF     = 500,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_MIN     = 5,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [3:0] cur_h_ten_i,
  input  logic [3:0] cur_h_one_i,
  input  logic [3:0] cur_m_ten_i,
  input  logic [3:0] cur_m_one_i,
  input  logic       minute_tick_i,
  input  logic       sec_tick_i,
  input  logic [3:0] alarm_h_ten_i,
  input  logic [3:0] alarm_h_one_i,
  input  logic [3:0] alarm_m_ten_i,
  input  logic [3:0] alarm_m_one_i,
  input  logic       alarm_set_done_i,
  input  logic       alarm_enable_i,
  input  logic       key_snooze_i,
  input  logic       key_dismiss_i,
  output logic       ring_o,
  output logic [7:0] leds_o,
  output logic [1:0] ctrl_state_o,
  output logic [3:0] eff_h_ten_o,
  output logic [3:0] eff_h_one_o,
  output logic [3:0] eff_m_ten_o,
  output logic [3:0] eff_m_one_o,
  output logic [2:0] snooze_cnt_o,
  output logic       set_err_o
);

  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int TO_W    = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;

  ctrl_state_e        state_q;
  bcd_time_t          target_q;
  bcd_time_t          eff_q;
  logic               target_valid_q;
  logic [2:0]         snooze_cnt_q;
  logic [BLINK_W-1:0] blink_q;
  logic [TO_W-1:0]    timeout_q;
  logic               ring_q;
  logic [7:0]         leds_q;
  logic               set_err_q;
  logic               set_done_q;
  logic               snooze_key_q;
  logic               dismiss_key_q;

  bcd_time_t   entry;
  bcd_time_t   cur;
  logic [15:0] eff_snoozed;
  logic        set_edge;
  logic        snooze_edge;
  logic        dismiss_edge;
  logic        entry_ok;
  logic        minute_match;
  logic        snooze_go;
  logic        timeout_hit;
  logic        blink_wrap;

  assign entry        = {alarm_h_ten_i, alarm_h_one_i, alarm_m_ten_i, alarm_m_one_i};
  assign cur          = {cur_h_ten_i, cur_h_one_i, cur_m_ten_i, cur_m_one_i};
  assign set_edge     = alarm_set_done_i & ~set_done_q;
  assign snooze_edge  = key_snooze_i & ~snooze_key_q;
  assign dismiss_edge = key_dismiss_i & ~dismiss_key_q;
  assign entry_ok     = bcd_time_valid(entry);
  assign minute_match = minute_tick_i && (cur == eff_q);
  assign snooze_go    = snooze_edge && (snooze_cnt_q < 3'(MAX_SNOOZE));
  assign timeout_hit  = sec_tick_i && (timeout_q == TO_W'(RING_TIMEOUT_S - 1));
  assign blink_wrap   = (blink_q == BLINK_W'(BLINK_HALF - 1));

  alarm_ring_ctrl_bcd_time_add #(
    .ADD_MIN (SNOOZE_MIN)
  ) u_snooze_add (
    .time_i (eff_q),
    .time_o (eff_snoozed)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      set_done_q    <= 1'b0;
      snooze_key_q  <= 1'b0;
      dismiss_key_q <= 1'b0;
    end else begin
      set_done_q    <= alarm_set_done_i;
      snooze_key_q  <= key_snooze_i;
      dismiss_key_q <= key_dismiss_i;
    end
  end

  // A rejected entry only raises set_err; it does not pre-empt the rest of the cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= ST_IDLE;
      target_q       <= '0;
      eff_q          <= '0;
      target_valid_q <= 1'b0;
      snooze_cnt_q   <= 3'd0;
      blink_q        <= '0;
      timeout_q      <= '0;
      ring_q         <= 1'b0;
      leds_q         <= LED_OFF;
      set_err_q      <= 1'b0;
    end else begin
      set_err_q <= set_edge && !entry_ok;
      if (set_edge && entry_ok) begin
        target_q       <= entry;
        eff_q          <= entry;
        target_valid_q <= 1'b1;
        snooze_cnt_q   <= 3'd0;
      end
      if (!alarm_enable_i) begin
        state_q <= ST_IDLE;
        ring_q  <= 1'b0;
        leds_q  <= LED_OFF;
      end else if (set_edge && entry_ok) begin
        state_q <= ST_ARMED;
        ring_q  <= 1'b0;
        leds_q  <= LED_OFF;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (target_valid_q) state_q <= ST_ARMED;
          end
          ST_ARMED, ST_SNOOZE: begin
            if ((state_q == ST_SNOOZE) && dismiss_edge) begin
              state_q      <= ST_ARMED;
              eff_q        <= target_q;
              snooze_cnt_q <= 3'd0;
            end else if (minute_match) begin
              state_q   <= ST_RINGING;
              ring_q    <= 1'b1;
              leds_q    <= LED_ON;
              blink_q   <= '0;
              timeout_q <= '0;
            end
          end
          ST_RINGING: begin
            // Timeout behaves as dismiss but ranks below an accepted snooze
            if (dismiss_edge || (timeout_hit && !snooze_go)) begin
              state_q      <= ST_ARMED;
              eff_q        <= target_q;
              snooze_cnt_q <= 3'd0;
              ring_q       <= 1'b0;
              leds_q       <= LED_OFF;
            end else if (snooze_go) begin
              state_q      <= ST_SNOOZE;
              eff_q        <= bcd_time_t'(eff_snoozed);
              snooze_cnt_q <= snooze_cnt_q + 3'd1;
              ring_q       <= 1'b0;
              leds_q       <= LED_OFF;
            end else begin
              if (blink_wrap) begin
                blink_q <= '0;
                leds_q  <= ~leds_q;
              end else begin
                blink_q <= blink_q + 1'b1;
              end
              if (sec_tick_i) timeout_q <= timeout_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign ring_o       = ring_q;
  assign leds_o       = leds_q;
  assign ctrl_state_o = state_q;
  assign eff_h_ten_o  = eff_q.h_ten;
  assign eff_h_one_o  = eff_q.h_one;
  assign eff_m_ten_o  = eff_q.m_ten;
  assign eff_m_one_o  = eff_q.m_one;
  assign snooze_cnt_o = snooze_cnt_q;
  assign set_err_o    = set_err_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb/tb_alarm_ring_ctrl.sv - self-checking bench for alarm_ring_ctrl
module tb_alarm_ring_ctrl;

  localparam int BLINK_HALF     = 500;
  localparam int RING_TIMEOUT_S = 60;
  localparam int SNOOZE_MIN     = 5;
  localparam int MAX_SNOOZE     = 3;
  localparam int S_IDLE = 0, S_ARMED = 1, S_RING = 2, S_SNOOZE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] c_ht = 0, c_ho = 0, c_mt = 0, c_mo = 0;
  logic [3:0] a_ht = 0, a_ho = 0, a_mt = 0, a_mo = 0;
  logic       minute_tick = 0, sec_tick = 0, set_done = 0, enable = 0;
  logic       key_snooze = 0, key_dismiss = 0;
  logic       ring;
  logic [7:0] leds;
  logic [1:0] ctrl_state;
  logic [3:0] e_ht, e_ho, e_mt, e_mo;
  logic [2:0] snooze_cnt;
  logic       set_err;

  always #5 clk = ~clk;

  alarm_ring_ctrl #(
    .BLINK_HALF(BLINK_HALF), .RING_TIMEOUT_S(RING_TIMEOUT_S),
    .SNOOZE_MIN(SNOOZE_MIN), .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cur_h_ten_i(c_ht), .cur_h_one_i(c_ho), .cur_m_ten_i(c_mt), .cur_m_one_i(c_mo),
    .minute_tick_i(minute_tick), .sec_tick_i(sec_tick),
    .alarm_h_ten_i(a_ht), .alarm_h_one_i(a_ho), .alarm_m_ten_i(a_mt), .alarm_m_one_i(a_mo),
    .alarm_set_done_i(set_done), .alarm_enable_i(enable),
    .key_snooze_i(key_snooze), .key_dismiss_i(key_dismiss),
    .ring_o(ring), .leds_o(leds), .ctrl_state_o(ctrl_state),
    .eff_h_ten_o(e_ht), .eff_h_one_o(e_ho), .eff_m_ten_o(e_mt), .eff_m_one_o(e_mo),
    .snooze_cnt_o(snooze_cnt), .set_err_o(set_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: times held as minute-of-day integers
  int m_state, m_target, m_eff, m_snz, m_ring_cyc, m_secs;
  bit m_tv, m_set_err, p_set, p_snz, p_dis;

  typedef struct {
    logic [3:0] ht, ho, mt, mo;
    bit         exp_err;
  } set_vec_t;
  set_vec_t   vecs[12];
  logic [15:0] t4_eff[3] = '{16'h1005, 16'h1010, 16'h1015};

  function automatic logic [15:0] to_bcd(int m);
    int h, mm;
    h  = m / 60;
    mm = m % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_target = 0; m_eff = 0; m_snz = 0; m_ring_cyc = 0; m_secs = 0;
    m_tv = 0; m_set_err = 0; p_set = 0; p_snz = 0; p_dis = 0;
  endtask

  task automatic model_dismiss();
    m_state = S_ARMED; m_eff = m_target; m_snz = 0;
  endtask

  task automatic model_step();
    bit se, ke, de, ok;
    int entry, cur;
    se = set_done && !p_set;
    ke = key_snooze && !p_snz;
    de = key_dismiss && !p_dis;
    p_set = set_done; p_snz = key_snooze; p_dis = key_dismiss;
    ok = (int'(a_ho) <= 9) && (int'(a_mo) <= 9) && (int'(a_mt) <= 5) &&
         (int'(a_ht) * 10 + int'(a_ho) < 24);
    entry = (int'(a_ht) * 10 + int'(a_ho)) * 60 + int'(a_mt) * 10 + int'(a_mo);
    cur   = (int'(c_ht) * 10 + int'(c_ho)) * 60 + int'(c_mt) * 10 + int'(c_mo);
    m_set_err = se && !ok;
    if (se && ok) begin
      m_target = entry; m_eff = entry; m_tv = 1; m_snz = 0;
    end
    if (!enable) m_state = S_IDLE;
    else if (se && ok) m_state = S_ARMED;
    else if (m_state == S_IDLE) begin
      if (m_tv) m_state = S_ARMED;
    end else if (m_state == S_ARMED || m_state == S_SNOOZE) begin
      if (m_state == S_SNOOZE && de) model_dismiss();
      else if (minute_tick && cur == m_eff) begin
        m_state = S_RING; m_ring_cyc = 0; m_secs = 0;
      end
    end else begin
      if (de) model_dismiss();
      else if (ke && m_snz < MAX_SNOOZE) begin
        m_state = S_SNOOZE; m_eff = (m_eff + SNOOZE_MIN) % 1440; m_snz++;
      end else begin
        m_ring_cyc++;
        if (sec_tick) begin
          m_secs++;
          if (m_secs == RING_TIMEOUT_S) model_dismiss();
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [7:0] exp_leds;
    exp_leds = (m_state == S_RING && ((m_ring_cyc / BLINK_HALF) % 2) == 0) ? 8'hFF : 8'h00;
    check("mdl_state", ctrl_state, m_state);
    check("mdl_ring", ring, (m_state == S_RING));
    check("mdl_leds", leds, exp_leds);
    check("mdl_eff", {e_ht, e_ho, e_mt, e_mo}, to_bcd(m_eff));
    check("mdl_snz", snooze_cnt, m_snz);
    check("mdl_set_err", set_err, m_set_err);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_cur(input int m);
    {c_ht, c_ho, c_mt, c_mo} = to_bcd(m);
  endtask

  task automatic tick();
    minute_tick = 1; cyc(); minute_tick = 0;
  endtask

  task automatic enter(input int m);
    {a_ht, a_ho, a_mt, a_mo} = to_bcd(m);
    set_done = 1; cyc(); set_done = 0; cyc();
  endtask

  task automatic press_dismiss();
    key_dismiss = 1; cyc(); key_dismiss = 0; cyc();
  endtask

  initial begin
    logic [15:0] last_good;
    vecs[0]  = '{4'd0, 4'd7, 4'd3, 4'd0, 1'b0};
    vecs[1]  = '{4'd2, 4'd3, 4'd5, 4'd9, 1'b0};
    vecs[2]  = '{4'd2, 4'd4, 4'd0, 4'd0, 1'b1};
    vecs[3]  = '{4'd2, 4'd5, 4'd0, 4'd0, 1'b1};
    vecs[4]  = '{4'd2, 4'd0, 4'd0, 4'd0, 1'b0};
    vecs[5]  = '{4'd1, 4'd9, 4'd5, 4'd9, 1'b0};
    vecs[6]  = '{4'd1, 4'd2, 4'd6, 4'd0, 1'b1};
    vecs[7]  = '{4'd0, 4'd9, 4'd5, 4'd10, 1'b1};
    vecs[8]  = '{4'd3, 4'd0, 4'd0, 4'd0, 1'b1};
    vecs[9]  = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b0};
    vecs[10] = '{4'd1, 4'd10, 4'd0, 4'd0, 1'b1};
    vecs[11] = '{4'd2, 4'd3, 4'd6, 4'd0, 1'b1};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", ctrl_state, 0);
    check("rst_ring", ring, 0);
    check("rst_leds", leds, 0);
    check("rst_eff", {e_ht, e_ho, e_mt, e_mo}, 0);
    check("rst_snz", snooze_cnt, 0);
    check("rst_set_err", set_err, 0);
    rst_n = 1;
    enable = 1;
    repeat (2) cyc();
    check("idle_no_target", ctrl_state, 0);

    last_good = 16'h0000;
    for (int i = 0; i < 12; i++) begin
      {a_ht, a_ho, a_mt, a_mo} = {vecs[i].ht, vecs[i].ho, vecs[i].mt, vecs[i].mo};
      if (!vecs[i].exp_err) last_good = {vecs[i].ht, vecs[i].ho, vecs[i].mt, vecs[i].mo};
      set_done = 1; cyc();
      check("vec_set_err", set_err, vecs[i].exp_err);
      check("vec_eff", {e_ht, e_ho, e_mt, e_mo}, last_good);
      check("vec_state", ctrl_state, 1);
      set_done = 0; cyc();
      check("vec_err_clear", set_err, 0);
    end

    // 1: ring at 07:30 and blink
    enter(450);
    check("t1_armed", ctrl_state, 1);
    set_cur(450); tick();
    check("t1_state", ctrl_state, 2);
    check("t1_ring", ring, 1);
    check("t1_leds_on", leds, 8'hFF);
    repeat (499) cyc();
    check("t1_leds_hold", leds, 8'hFF);
    cyc();
    check("t1_leds_off", leds, 8'h00);
    repeat (500) cyc();
    check("t1_leds_on2", leds, 8'hFF);

    // 2: snooze to 07:35 and ring again
    key_snooze = 1; cyc();
    check("t2_state", ctrl_state, 3);
    check("t2_eff", {e_ht, e_ho, e_mt, e_mo}, 16'h0735);
    check("t2_snz", snooze_cnt, 1);
    check("t2_ring", ring, 0);
    key_snooze = 0; cyc();
    set_cur(455); tick();
    check("t2_ring_again", ring, 1);
    press_dismiss();
    check("t2_dismiss_eff", {e_ht, e_ho, e_mt, e_mo}, 16'h0730);

    // 3: snooze across midnight
    enter(23 * 60 + 58);
    set_cur(23 * 60 + 58); tick();
    check("t3_ring", ring, 1);
    key_snooze = 1; cyc(); key_snooze = 0;
    check("t3_eff_wrap", {e_ht, e_ho, e_mt, e_mo}, 16'h0003);
    cyc();
    set_cur(3); tick();
    check("t3_ring_again", ctrl_state, 2);
    press_dismiss();

    // 4: snooze limit
    enter(600);
    for (int k = 0; k < 3; k++) begin
      set_cur(600 + 5 * k); tick();
      check("t4_ringing", ring, 1);
      key_snooze = 1; cyc(); key_snooze = 0;
      check("t4_snz", snooze_cnt, k + 1);
      check("t4_eff", {e_ht, e_ho, e_mt, e_mo}, t4_eff[k]);
      cyc();
    end
    set_cur(615); tick();
    key_snooze = 1; cyc(); key_snooze = 0;
    check("t4_ignored_state", ctrl_state, 2);
    check("t4_ignored_ring", ring, 1);
    check("t4_ignored_snz", snooze_cnt, 3);
    cyc();
    key_dismiss = 1; cyc(); key_dismiss = 0;
    check("t4_dis_state", ctrl_state, 1);
    check("t4_dis_eff", {e_ht, e_ho, e_mt, e_mo}, 16'h1000);
    check("t4_dis_snz", snooze_cnt, 0);
    cyc();

    // 5: timeout and snooze+dismiss together
    set_cur(600); tick();
    for (int i = 0; i < RING_TIMEOUT_S; i++) begin
      sec_tick = 1; cyc(); sec_tick = 0;
      if (i == RING_TIMEOUT_S - 2) check("t5_still_ringing", ring, 1);
      if (i < RING_TIMEOUT_S - 1) cyc();
    end
    check("t5_to_state", ctrl_state, 1);
    check("t5_to_ring", ring, 0);
    check("t5_to_leds", leds, 0);
    set_cur(600); tick();
    key_snooze = 1; key_dismiss = 1; cyc();
    key_snooze = 0; key_dismiss = 0;
    check("t5_both_state", ctrl_state, 1);
    check("t5_both_snz", snooze_cnt, 0);
    cyc();

    // 6: bad entry, disable mid-ring, reset mid-ring
    {a_ht, a_ho, a_mt, a_mo} = 16'h2500;
    set_done = 1; cyc();
    check("t6_err", set_err, 1);
    check("t6_err_state", ctrl_state, 1);
    check("t6_err_eff", {e_ht, e_ho, e_mt, e_mo}, 16'h1000);
    set_done = 0; cyc();
    check("t6_err_pulse", set_err, 0);
    set_cur(600); tick();
    enable = 0; cyc();
    check("t6_dis_state", ctrl_state, 0);
    check("t6_dis_ring", ring, 0);
    check("t6_dis_leds", leds, 0);
    enable = 1; cyc();
    check("t6_reenable", ctrl_state, 1);
    tick();
    check("t6_ring_before_rst", ring, 1);
    #2 rst_n = 0;
    #1;
    check("t6_rst_state", ctrl_state, 0);
    check("t6_rst_ring", ring, 0);
    check("t6_rst_leds", leds, 0);
    check("t6_rst_eff", {e_ht, e_ho, e_mt, e_mo}, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    repeat (3) cyc();
    check("t6_alarm_lost", ctrl_state, 0);

    // Randomized traffic against the model
    enter(300);
    for (int i = 0; i < 8000; i++) begin
      minute_tick = ($urandom_range(0, 15) == 0);
      if (minute_tick) begin
        if ($urandom_range(0, 1) == 1) set_cur(m_eff);
        else set_cur($urandom_range(0, 1439));
      end
      sec_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 40) == 0) key_snooze = ~key_snooze;
      if ($urandom_range(0, 60) == 0) key_dismiss = ~key_dismiss;
      if ($urandom_range(0, 150) == 0) begin
        set_done = ~set_done;
        if (set_done) begin
          if ($urandom_range(0, 1) == 1) {a_ht, a_ho, a_mt, a_mo} = to_bcd($urandom_range(0, 1439));
          else {a_ht, a_ho, a_mt, a_mo} = 16'($urandom);
        end
      end
      if ($urandom_range(0, 400) == 0) enable = ~enable;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
